// File: rtl/spectrum_frame_assembler.sv
// spectrum_frame_assembler
//   Writer side of the first maxima-reduction stage. Collects a serial stream
//   of FFT magnitude bins (valid/ready) into a SIZE-entry frame register and
//   strobes `load` for one cycle once the downstream reduction tree reports
//   it can take a frame.
//
// Ports
//   clk, reset_n       clock (rising edge), async active-low reset
//   in_valid/in_ready  sample handshake; in_data is bin magnitude, in_last
//                      marks the final bin (only checked with the macro)
//   frame_ready        downstream idle, sampled only while waiting to load
//   load               one-cycle strobe, `out` holds a complete frame
//   out[i]             bin i of the assembled frame
//   frame_err          one-cycle pulse on a framing error
//   frame_count        number of load strobes, wraps at 2^16
//
// Optional feature macro: FRAME_LAST_CHECK_EN
//   Defined   : in_last is checked against the bin count; early or missing
//               in_last pulses frame_err and the frame is never loaded.
//   Undefined : frames are delimited by count only, frame_err is always 0.
module spectrum_frame_assembler #(
  parameter int SIZE   = 512,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              frame_ready,
  output logic              load,
  output logic [DATA_W-1:0] out [SIZE-1:0],
  output logic              frame_err,
  output logic [15:0]       frame_count
);

  localparam int IDX_W = $clog2(SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

  typedef enum logic [1:0] {S_FILL, S_WAIT, S_LOAD, S_DROP} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [DATA_W-1:0] out_q [SIZE-1:0];
  logic              in_ready_q, load_q, frame_err_q;
  logic [15:0]       frame_count_q;
  logic              accept, wr_en, err_d;

  // Only the registered ready gates acceptance, so there is no
  // combinational path from in_valid to in_ready.
  assign accept = in_valid & in_ready_q;

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    wr_en    = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_FILL: begin
        if (accept) begin
          wr_en    = 1'b1;
          wr_idx_d = wr_idx_q + 1'b1;
`ifdef FRAME_LAST_CHECK_EN
          if (wr_idx_q == LAST_IDX) begin
            if (in_last) begin
              state_d = S_WAIT;
            end else begin
              // Full count reached without a delimiter: discard until in_last.
              err_d    = 1'b1;
              state_d  = S_DROP;
              wr_idx_d = '0;
            end
          end else if (in_last) begin
            // Short frame: restart the count, never load it.
            err_d    = 1'b1;
            wr_idx_d = '0;
          end
`else
          if (wr_idx_q == LAST_IDX) state_d = S_WAIT;
`endif
        end
      end
      S_WAIT: if (frame_ready) state_d = S_LOAD;
      S_LOAD: begin
        state_d  = S_FILL;
        wr_idx_d = '0;
      end
      S_DROP: begin
`ifdef FRAME_LAST_CHECK_EN
        if (accept && in_last) begin
          state_d  = S_FILL;
          wr_idx_d = '0;
        end
`else
        state_d = S_FILL;
`endif
      end
      default: state_d = S_FILL;
    endcase
  end

  // Handshake/strobe outputs are decoded from the next state so they are
  // registered yet line up with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_FILL;
      wr_idx_q      <= '0;
      in_ready_q    <= 1'b0;
      load_q        <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      in_ready_q  <= (state_d == S_FILL) || (state_d == S_DROP);
      load_q      <= (state_d == S_LOAD);
      frame_err_q <= err_d;
      if (state_d == S_LOAD) frame_count_q <= frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SIZE; i++) out_q[i] <= '0;
    end else if (wr_en) begin
      out_q[wr_idx_q] <= in_data;
    end
  end

`ifndef FRAME_LAST_CHECK_EN
  logic unused_in_last;
  assign unused_in_last = in_last;
`endif

  assign in_ready    = in_ready_q;
  assign load        = load_q;
  assign frame_err   = frame_err_q;
  assign frame_count = frame_count_q;
  assign out         = out_q;

endmodule

// File: doc/spectrum_frame_assembler.md
# spectrum_frame_assembler

- Writer side of the first maxima-reduction stage.
- Accepts a serial stream of 16-bit FFT magnitude bins over a valid/ready handshake and assembles them into a parallel SIZE-wide frame register.
- Pulses `load` for one cycle to hand the complete frame to the maxima pipeline, but only when that pipeline reports it can accept a frame.
- Sits between the FFT magnitude stage and the find-maxima reduction tree.

## Interface
Parameters:
- `SIZE`, 512: bins per frame; power of two, ≥ 4.
- `DATA_W`, 16: magnitude width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: `in_data` valid.
- `in_data`  in  DATA_W: magnitude of the current bin. Bins arrive in order 0..SIZE-1.
- `in_last`  in  1: marks the final bin of a frame. Used only with `FRAME_LAST_CHECK_EN`.
- `in_ready`  out  1: assembler can accept a sample.
- `frame_ready`  in  1: downstream reduction pipeline idle and able to capture a frame.
- `load`  out  1: one-cycle strobe; `out` holds a complete frame.
- `out`  out  DATA_W × SIZE (unpacked [SIZE-1:0]): assembled frame. `out[i]` holds bin i.
- `frame_err`  out  1: one-cycle pulse on a framing error.
- `frame_count`  out  16: number of `load` strobes issued; wraps modulo 2^16.

## Operation
- Write index `wr_idx` is $clog2(SIZE) bits. A sample is accepted on any edge where `in_valid & in_ready`; the sample is stored to `out[wr_idx]` and `wr_idx` increments.
- States:
  - FILL: `in_ready`=1. Accepting bin SIZE-1 moves the FSM to WAIT.
  - WAIT: `in_ready`=0; `out` frozen. If `frame_ready`=1, the FSM moves to LOAD; otherwise it stays in WAIT indefinitely.
  - LOAD: `load`=1 for exactly one cycle; `in_ready`=0; `frame_count` increments; `wr_idx` clears to 0. The FSM then moves to FILL.
  - DROP (only with the macro): `in_ready`=1; accepted samples are discarded. Acceptance of a sample with `in_last`=1 moves the FSM to FILL with `wr_idx`=0.
- `out` changes only on accepted writes. Bins not yet rewritten in the current frame keep their previous values.
- Bin 0 is stored as received. DC suppression is downstream's job.
- `load`, `in_ready`, `frame_err` and `frame_count` are registered outputs with no combinational path from inputs.
- Reset (asynchronous, any state):
  - `in_ready`=0, `load`=0, `frame_err`=0, `frame_count`=0, `wr_idx`=0, all `out` entries 0, state FILL.
  - `in_ready` rises on the first clock edge after `reset_n` deasserts.
  - Any partial frame is lost. A pending LOAD is cancelled.

## Timing
- Let cycle N be the cycle in which bin SIZE-1 is accepted.
  - Cycle N+1: WAIT, `in_ready`=0.
  - If `frame_ready`=1 in cycle N+1, then `load`=1 in cycle N+2 and `in_ready`=1 in cycle N+3.
- Minimum frame period is SIZE+2 cycles. Two dead cycles occur per frame.
- `frame_ready` is sampled only in WAIT. Its value in FILL or LOAD is ignored.
- `out` is stable from cycle N+1 through the `load` cycle inclusive. The first write of the next frame lands at the earliest one edge after the `load` cycle.
- `frame_err` is asserted in the cycle following the offending handshake.

## Configuration
- `FRAME_LAST_CHECK_EN` defined:
  - Early `in_last` (accepted with `wr_idx` < SIZE-1): `frame_err` pulses, `wr_idx` is cleared to 0, state stays FILL. The short frame is never loaded.
  - Missing `in_last` on bin SIZE-1: `frame_err` pulses and the FSM moves to DROP. No load occurs for that frame.
  - Correct `in_last` on bin SIZE-1: normal move to WAIT.
- Undefined:
  - `in_last` is ignored and DROP is unreachable.
  - Frames are delimited by count only; `frame_err` is tied to 0.

## Test plan
- Reset release with `in_valid`=1 → `in_ready`=0 during reset and 1 at the first edge after release. `out[*]`=0 and `frame_count`=0.
- Stream bins with `in_data`=i+1 for SIZE=8, `frame_ready` held at 1 → `load` pulses exactly once, 2 cycles after bin 7 is accepted. `out[i]`=i+1 at the load cycle; `frame_count`=1.
- Hold `frame_ready`=0 for 20 cycles after a full frame → `in_ready`=0 and `out` unchanged for all 20 cycles. `load` fires 1 cycle after `frame_ready` rises.
- With macro, `in_last` asserted on bin 3 (SIZE=8) → `frame_err` pulses once and no `load`. The next 8 bins form a valid frame that loads.
- With macro, bin 7 sent without `in_last`, then 3 more samples with `in_last` on the third → `frame_err` pulse, the 3 samples are discarded, no `load`, then normal fill resumes at `wr_idx`=0.
- Assert `reset_n`=0 mid-fill (`wr_idx`=5) and while in WAIT → outputs clear immediately (asynchronously), no `load` is emitted, `frame_count` reads 0.
